// File: rtl/vc_dest_arbiter.sv
// Pops words from two virtual-channel FIFOs (VC0 priority, VC1 starvation guard)
// and routes each word to destination FIFO D0 or D1 from one bit of the word.
module vc_dest_arbiter #(
    parameter int data_width   = 6,
    parameter int DEST_BIT     = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_vc0_empty,
    input  logic                  i_vc1_empty,
    input  logic [data_width-1:0] i_vc0_data,
    input  logic [data_width-1:0] i_vc1_data,
    input  logic                  i_d0_almost_full,
    input  logic                  i_d1_almost_full,
    input  logic                  i_d0_full,
    input  logic                  i_d1_full,
    output logic                  o_vc0_pop,
    output logic                  o_vc1_pop,
    output logic                  o_d0_push,
    output logic                  o_d1_push,
    output logic [data_width-1:0] o_d_data,
    output logic [CNT_WIDTH-1:0]  o_cnt_d0,
    output logic [CNT_WIDTH-1:0]  o_cnt_d1,
    output logic                  o_overflow_error,
    output logic                  o_idle
);

    localparam logic [3:0] LP_STARVE = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_starve_cnt;
    logic                  r_pend_valid;
    logic                  r_pend_src;
    logic [data_width-1:0] r_d_data;
    logic [1:0]            r_push;
    logic [1:0]            w_push_next;
    logic [1:0]            w_full;
    logic                  r_overflow;
    logic                  w_pause;
    logic                  w_force1;
    logic                  w_vc0_pop;
    logic                  w_vc1_pop;
    logic [data_width-1:0] w_sel;

    // Destination is unknown until the word is read, so either flag stalls.
    assign w_pause  = i_d0_almost_full | i_d1_almost_full;
    assign w_force1 = (r_starve_cnt == LP_STARVE) & ~i_vc1_empty;
    assign w_full   = {i_d1_full, i_d0_full};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = IDLE;
        w_vc0_pop    = 1'b0;
        w_vc1_pop    = 1'b0;
        if (w_pause) begin
            w_state_next = STALL;
        end else if (~i_vc0_empty | ~i_vc1_empty) begin
            w_state_next = ACTIVE;
        end
        if (r_state == ACTIVE) begin
            w_vc1_pop = ~i_vc1_empty & (i_vc0_empty | w_force1);
            w_vc0_pop = ~i_vc0_empty & ~w_force1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_starve_cnt <= 4'd0;
        end else if (w_vc1_pop || i_vc1_empty) begin
            r_starve_cnt <= 4'd0;
        end else if (w_vc0_pop && (r_starve_cnt != LP_STARVE)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // FIFO read data is valid the cycle after the pop; route it from the pending source.
    assign w_sel       = r_pend_src ? i_vc1_data : i_vc0_data;
    assign w_push_next = {r_pend_valid & w_sel[DEST_BIT], r_pend_valid & ~w_sel[DEST_BIT]};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pend_valid <= 1'b0;
            r_pend_src   <= 1'b0;
            r_push       <= 2'b00;
            r_d_data     <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_pend_valid <= w_vc0_pop | w_vc1_pop;
            r_pend_src   <= w_vc1_pop;
            r_push       <= w_push_next;
            if (r_pend_valid) begin
                r_d_data <= w_sel;
            end
            if (|(r_push & w_full)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_dest
            logic [CNT_WIDTH-1:0] r_cnt;
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_cnt <= '0;
                end else if (r_push[gi]) begin
                    r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    assign o_vc0_pop        = w_vc0_pop;
    assign o_vc1_pop        = w_vc1_pop;
    assign o_d0_push        = r_push[0];
    assign o_d1_push        = r_push[1];
    assign o_d_data         = r_d_data;
    assign o_cnt_d0         = gen_dest[0].r_cnt;
    assign o_cnt_d1         = gen_dest[1].r_cnt;
    assign o_overflow_error = r_overflow;
    assign o_idle           = (r_state == IDLE) & ~r_pend_valid & ~r_push[0] & ~r_push[1];

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Directed bench for vc_dest_arbiter: behavioural VC FIFOs feed the DUT and a
// scoreboard checks every pushed word against the expected pop order.
module tb_vc_dest_arbiter;

    localparam int DW       = 6;
    localparam int DEST_BIT = 4;
    localparam int CW       = 5;

    logic          clk;
    logic          reset;
    logic          vc0_empty;
    logic          vc1_empty;
    logic [DW-1:0] vc0_data;
    logic [DW-1:0] vc1_data;
    logic          d0_almost_full;
    logic          d1_almost_full;
    logic          d0_full;
    logic          d1_full;
    logic          vc0_pop;
    logic          vc1_pop;
    logic          d0_push;
    logic          d1_push;
    logic [DW-1:0] d_data;
    logic [CW-1:0] cnt_d0;
    logic [CW-1:0] cnt_d1;
    logic          overflow_error;
    logic          idle;

    vc_dest_arbiter #(
        .data_width(DW), .DEST_BIT(DEST_BIT), .STARVE_LIMIT(4), .CNT_WIDTH(CW)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .i_vc0_empty(vc0_empty), .i_vc1_empty(vc1_empty),
        .i_vc0_data(vc0_data), .i_vc1_data(vc1_data),
        .i_d0_almost_full(d0_almost_full), .i_d1_almost_full(d1_almost_full),
        .i_d0_full(d0_full), .i_d1_full(d1_full),
        .o_vc0_pop(vc0_pop), .o_vc1_pop(vc1_pop),
        .o_d0_push(d0_push), .o_d1_push(d1_push), .o_d_data(d_data),
        .o_cnt_d0(cnt_d0), .o_cnt_d1(cnt_d1),
        .o_overflow_error(overflow_error), .o_idle(idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            n_assert = 0;
    int            n_fail   = 0;
    int            n_push   = 0;
    logic          last_p0;
    logic          last_p1;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] exp_out[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: starts and ends 1 time unit after a rising edge.
    task automatic tick();
        logic [DW-1:0] w;
        #3;
        last_p0 = vc0_pop;
        last_p1 = vc1_pop;
        @(posedge clk);
        #1;
        if (d0_push || d1_push) begin
            n_push++;
            $display("t=%0t push d0=%0b d1=%0b data=%h cnt_d0=%0d cnt_d1=%0d",
                     $time, d0_push, d1_push, d_data, cnt_d0, cnt_d1);
            if (exp_out.size() == 0) begin
                chk("spurious_push", {d1_push, d0_push}, 0);
            end else begin
                w = exp_out.pop_front();
                chk("push_data", d_data, w);
                chk("push_route", {d1_push, d0_push}, w[DEST_BIT] ? 2 : 1);
            end
        end
        if (last_p0) begin
            if (q0.size() == 0) chk("pop_on_empty_vc0", last_p0, 0);
            else begin w = q0.pop_front(); vc0_data = w; exp_out.push_back(w); end
        end
        if (last_p1) begin
            if (q1.size() == 0) chk("pop_on_empty_vc1", last_p1, 0);
            else begin w = q1.pop_front(); vc1_data = w; exp_out.push_back(w); end
        end
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
    endtask

    initial begin
        int np;
        reset = 1'b1;
        vc0_empty = 1'b1; vc1_empty = 1'b1;
        vc0_data = '0; vc1_data = '0;
        d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        d0_full = 1'b0; d1_full = 1'b0;
        #2;
        chk("rst_vc0_pop", vc0_pop, 0);
        chk("rst_vc1_pop", vc1_pop, 0);
        chk("rst_push", {d1_push, d0_push}, 0);
        chk("rst_d_data", d_data, 0);
        chk("rst_cnts", {cnt_d1, cnt_d0}, 0);
        chk("rst_ovf", overflow_error, 0);
        chk("rst_idle", idle, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Routing and fixed 2-cycle pop->push latency
        q0.push_back(6'h05); q0.push_back(6'h15); vc0_empty = 1'b0;
        tick(); chk("t2_flag_latency", last_p0, 0);
        tick(); chk("t2_pop_n", last_p0, 1);
        tick(); chk("t2_pop_n1", last_p0, 1);
        chk("t2_d0_push", {d1_push, d0_push}, 2'b01);
        chk("t2_data05", d_data, 6'h05);
        tick(); chk("t2_no_pop", last_p0, 0);
        chk("t2_d1_push", {d1_push, d0_push}, 2'b10);
        chk("t2_data15", d_data, 6'h15);
        chk("t2_cnt_d0", cnt_d0, 1);
        tick();
        chk("t2_cnt_d1", cnt_d1, 1);
        chk("t2_no_push", {d1_push, d0_push}, 0);
        chk("t2_data_hold", d_data, 6'h15);
        chk("t2_idle", idle, 1);

        // Priority with starvation guard: VC0 x4, VC1, VC0 x4, VC1, then VC1 only
        for (int i = 0; i < 8; i++) begin
            q0.push_back(6'(8'h01 + i));
            q1.push_back(6'(8'h11 + i));
        end
        vc0_empty = 1'b0; vc1_empty = 1'b0;
        tick(); chk("t3_idle_first", {last_p1, last_p0}, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("t3_pop_order_%0d", i), {last_p1, last_p0},
                ((i == 4) || (i >= 9)) ? 2'b10 : 2'b01);
        end
        tick(); tick(); tick();
        chk("t3_cnt_d0", cnt_d0, 9);
        chk("t3_cnt_d1", cnt_d1, 9);

        // Backpressure during a streaming transfer
        for (int i = 0; i < 10; i++) q0.push_back(6'(8'h20 + i));
        vc0_empty = 1'b0;
        tick();
        tick(); chk("t4_pop_c1", last_p0, 1);
        tick(); chk("t4_pop_c2", last_p0, 1);
        d1_almost_full = 1'b1;
        np = n_push;
        tick(); chk("t4_pop_after_af", last_p0, 1);
        tick(); chk("t4_stalled_c4", last_p0, 0);
        tick(); chk("t4_stalled_c5", last_p0, 0);
        tick(); chk("t4_stalled_c6", last_p0, 0);
        chk("t4_pushes_in_stall", n_push - np, 2);
        chk("t4_not_idle", idle, 0);
        d1_almost_full = 1'b0;
        tick(); chk("t4_resume_latency", last_p0, 0);
        tick(); chk("t4_resume", last_p0, 1);
        for (int i = 0; i < 9; i++) tick();
        chk("t4_cnt_d0", cnt_d0, 19);
        chk("t4_cnt_d1", cnt_d1, 9);

        // Overflow: D0 full while a D0-bound word is in flight
        q0.push_back(6'h0A); vc0_empty = 1'b0;
        tick(); tick();
        d0_full = 1'b1;
        tick();
        chk("t5_push_issued", d0_push, 1);
        chk("t5_ovf_pre", overflow_error, 0);
        tick();
        chk("t5_ovf_set", overflow_error, 1);
        d0_full = 1'b0;
        tick(); tick();
        chk("t5_ovf_sticky", overflow_error, 1);
        chk("t5_cnt_d0", cnt_d0, 20);

        // Reset mid-stream with a word pending
        q0.push_back(6'h01); q0.push_back(6'h02); q0.push_back(6'h03); vc0_empty = 1'b0;
        tick(); tick();
        #1 reset = 1'b1;
        #1;
        chk("t1_vc0_pop", vc0_pop, 0);
        chk("t1_push", {d1_push, d0_push}, 0);
        chk("t1_d_data", d_data, 0);
        chk("t1_cnts", {cnt_d1, cnt_d0}, 0);
        chk("t1_ovf", overflow_error, 0);
        chk("t1_idle", idle, 1);
        q0.delete(); exp_out.delete();
        vc0_empty = 1'b1; vc0_data = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_no_push_after", {d1_push, d0_push}, 0);
            chk("t1_idle_after", idle, 1);
        end

        // Counter wrap: 33 words to D0
        for (int i = 0; i < 33; i++) q0.push_back(6'(i % 16));
        vc0_empty = 1'b0;
        tick();
        for (int i = 0; i < 33; i++) tick();
        tick(); tick();
        chk("t6_cnt_d0_wrap", cnt_d0, 1);
        chk("t6_cnt_d1", cnt_d1, 0);
        chk("t6_idle", idle, 1);
        chk("t6_all_delivered", exp_out.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_dest_arbiter.md
Name: vc_dest_arbiter

Overview:
Downstream stage of the two virtual-channel FIFOs (VC0, VC1). Pops words from the VC FIFOs with VC0 priority plus a starvation guard for VC1. Routes each popped word to destination FIFO D0 or D1 according to one destination bit in the word. Applies backpressure from the destination almost-full flags and counts words delivered per destination.

Parameters:
data_width, 6, word width; must match the VC FIFOs.
DEST_BIT, 4, index of the data bit that selects the destination: 0 -> D0, 1 -> D1.
STARVE_LIMIT, 4, consecutive VC0 grants allowed while VC1 is non-empty; then VC1 is forced. Range 1..15.
CNT_WIDTH, 5, width of the per-destination delivered-word counters.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
vc0_empty  in  1  VC0 FIFO empty flag
vc1_empty  in  1  VC1 FIFO empty flag
vc0_data  in  data_width  VC0 read data, valid the cycle after vc0_pop
vc1_data  in  data_width  VC1 read data, valid the cycle after vc1_pop
d0_almost_full  in  1  D0 almost-full flag
d1_almost_full  in  1  D1 almost-full flag
d0_full  in  1  D0 full flag
d1_full  in  1  D1 full flag
vc0_pop  out  1  read enable to VC0
vc1_pop  out  1  read enable to VC1
d0_push  out  1  write enable to D0, registered
d1_push  out  1  write enable to D1, registered
d_data  out  data_width  write data to D0/D1, registered
cnt_d0  out  CNT_WIDTH  words pushed to D0, wraps
cnt_d1  out  CNT_WIDTH  words pushed to D1, wraps
overflow_error  out  1  sticky: a push was issued to a full destination
idle  out  1  no pending work and no word in flight

Behaviour:
- Reset (asynchronous, active-high): all of the following go to 0 immediately; reset overrides all activity, including mid-transfer, and in-flight words are dropped.
  - state=IDLE, starve_cnt, pend_valid, pend_src.
  - vc0_pop, vc1_pop, d0_push, d1_push, d_data, cnt_d0, cnt_d1, overflow_error.
  - idle=1.
- pause = d0_almost_full | d1_almost_full. The destination is unknown before the read, so either flag stalls the block.
- FSM, states IDLE, ACTIVE, STALL, registered and updated every clk:
  - next = STALL if pause.
  - else ACTIVE if ~vc0_empty | ~vc1_empty.
  - else IDLE.
  - Consequence: there is one cycle of latency from a flag change to a pop response.
- Pops are combinational and only in state ACTIVE, with at most one pop per cycle:
  - force1 = (starve_cnt == STARVE_LIMIT) & ~vc1_empty.
  - vc1_pop = ACTIVE & ~vc1_empty & (vc0_empty | force1).
  - vc0_pop = ACTIVE & ~vc0_empty & ~force1.
  - A pop is never issued to an empty FIFO.
- starve_cnt:
  - +1 on a vc0_pop while vc1_empty=0.
  - Cleared on vc1_pop or whenever vc1_empty=1.
  - Saturates at STARVE_LIMIT.
- Pipeline:
  - Pop at cycle N: pend_valid<=1 and pend_src<=VC id, at edge end of N.
  - Cycle N+1: sel = pend_src ? vc1_data : vc0_data.
    - d_data<=sel.
    - d0_push<=pend_valid & ~sel[DEST_BIT].
    - d1_push<=pend_valid & sel[DEST_BIT].
  - Push is visible in cycle N+2. Fixed latency is pop->push = 2 cycles.
  - Back-to-back pops give back-to-back pushes, throughput 1 word/cycle.
  - When no push occurs, d0_push=d1_push=0 and d_data holds its last value.
- Words in flight are never cancelled by pause; up to 3 words may be pushed after almost_full rises. Destination almost-full thresholds must leave 3 free slots.
- cnt_dX increments in the cycle dX_push is high and wraps modulo 2^CNT_WIDTH.
- overflow_error is set when dX_push=1 while dX_full=1, and cleared only by reset. The push is still issued; no drop logic is included.
- idle = (state==IDLE) & ~pend_valid & ~d0_push & ~d1_push.

Test Plan:
1. Reset mid-stream: assert reset while pend_valid=1 -> all outputs 0 in the same cycle without waiting for clk; idle=1; no push after reset deasserts.
2. Routing and latency: VC0 holds {6'h05, 6'h15} with DEST_BIT=4, D FIFOs empty -> vc0_pop at N and N+1; d0_push at N+2 with d_data=05; d1_push at N+3 with d_data=15; cnt_d0=1, cnt_d1=1.
3. Priority and starvation: both VCs hold 8 words, STARVE_LIMIT=4 -> pop order VC0×4, VC1, VC0×4, VC1, ...; once VC0 is empty, VC1 is popped every cycle.
4. Backpressure: d1_almost_full rises during a streaming transfer -> pops stop one cycle later; at most 3 further pushes; state=STALL; pops resume one cycle after the flag falls.
5. Overflow: drive d0_full=1 while a D0-bound word is in flight -> d0_push=1 and overflow_error=1, which stays high until reset.
6. Counter wrap: push 33 words to D0 with CNT_WIDTH=5 -> cnt_d0=1; idle=1 after the last push.
